// File: rtl/alu_mc.sv
// Registered ALU with valid/ready issue, a carry/overflow flag register and an
// optional iterative shift-and-add multiplier on opcode 4'b1111.
module alu_mc #(
  parameter int W      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] r_i,
  input  logic [W:0]   imm_i,
  output logic         valid_o,
  output logic [W-1:0] out_o,
  output logic         branch_o,
  output logic         ovf_o
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] SH_LIM = W'(W);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_next;

  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] acc_reg;
  logic [CW-1:0]  count_reg;

  logic           accept;
  logic           ovr;
  logic           start_mul;
  logic [W-1:0]   alu_res;
  logic           alu_br;
  logic           alu_f_we;
  logic           alu_f_next;
  logic [W:0]     sum_w;
  logic [W-1:0]   diff;
  logic [2*W-1:0] acc_sum;

  assign ovr       = ~imm_i[W];
  assign start_mul = MUL_EN && (op_i == 4'b1111) && !ovr;
  assign sum_w     = {1'b0, a_i} + {1'b0, r_i} + {{W{1'b0}}, ovf_o};
  assign diff      = a_i - r_i;
  assign acc_sum   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    alu_res    = '0;
    alu_br     = 1'b0;
    alu_f_we   = 1'b0;
    alu_f_next = 1'b0;
    case (op_i)
      4'b0000, 4'b0010, 4'b0011: alu_res = r_i;
      4'b0001, 4'b1100:          alu_res = a_i;
      4'b0100: begin
        alu_res    = sum_w[W-1:0];
        alu_f_we   = 1'b1;
        alu_f_next = sum_w[W];
      end
      4'b0101: alu_res = diff;
      4'b0110: alu_res = a_i & r_i;
      4'b1011: alu_res = a_i ^ r_i;
      4'b0111: begin
        if (a_i == {{(W-1){1'b0}}, 1'b1}) begin
          alu_br  = 1'b1;
          alu_res = r_i;
        end
      end
      4'b1000: begin
        if (a_i == '0) begin
          alu_br  = 1'b1;
          alu_res = r_i;
        end
      end
      4'b1001: alu_res = {{(W-1){1'b0}}, (a_i == r_i)};
      4'b1010: alu_res = {{(W-1){1'b0}}, diff[W-1]};
      4'b1101: alu_res = (r_i < SH_LIM) ? (a_i << r_i) : '0;
      4'b1110: alu_res = (r_i < SH_LIM) ? (a_i >> r_i) : '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    ready_o    = (state == IDLE);
    accept     = valid_i && ready_o;
    case (state)
      IDLE: if (accept && start_mul) state_next = MUL;
      MUL:  if (count_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Bit 0 of the multiplier is folded into the load so the loop needs only W-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      out_o      <= '0;
      branch_o   <= 1'b0;
      ovf_o      <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else begin
      valid_o  <= 1'b0;
      branch_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_mul) begin
              mcand_reg  <= {{(W-1){1'b0}}, a_i, 1'b0};
              mplier_reg <= r_i >> 1;
              acc_reg    <= r_i[0] ? {{W{1'b0}}, a_i} : '0;
              count_reg  <= CW'(W - 2);
            end else begin
              valid_o  <= 1'b1;
              out_o    <= ovr ? imm_i[W-1:0] : alu_res;
              branch_o <= alu_br;
              if (alu_f_we && !ovr) ovf_o <= alu_f_next;
            end
          end
        end
        MUL: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg - 1'b1;
          if (count_reg == '0) begin
            valid_o <= 1'b1;
            out_o   <= acc_sum[W-1:0];
            ovf_o   <= |acc_sum[2*W-1:W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed plus randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [3:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] r_i = '0;
  logic [W:0]   imm_i = '0;
  logic         valid_o;
  logic [W-1:0] out_o;
  logic         branch_o;
  logic         ovf_o;

  int tests = 0;
  int failed = 0;
  int mf = 0;

  always #5 clk = ~clk;

  alu_mc #(.W(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .r_i(r_i), .imm_i(imm_i),
    .valid_o(valid_o), .out_o(out_o), .branch_o(branch_o), .ovf_o(ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic; updates the model flag mf.
  function automatic void model(input int op, input int a, input int r, input int imm,
                                output int res, output int br, output int mul);
    int s;
    int p;
    bit ov;
    ov  = (imm < M);
    res = 0;
    br  = 0;
    mul = 0;
    case (op)
      0, 2, 3: res = r;
      1, 12:   res = a;
      4: begin
        s = a + r + mf;
        res = s % M;
        if (!ov) mf = (s >= M) ? 1 : 0;
      end
      5:  res = (a - r + M) % M;
      6:  res = a & r;
      11: res = a ^ r;
      7:  if (a == 1) begin br = 1; res = r; end
      8:  if (a == 0) begin br = 1; res = r; end
      9:  res = (a == r) ? 1 : 0;
      10: res = (((a - r + M) % M) >= M / 2) ? 1 : 0;
      13: res = (r >= W) ? 0 : (a * (1 << r)) % M;
      14: res = (r >= W) ? 0 : a / (1 << r);
      15: if (!ov) begin
        p = a * r;
        res = p % M;
        mf = (p >= M) ? 1 : 0;
        mul = 1;
      end
      default: res = 0;
    endcase
    if (ov) res = imm % M;
  endfunction

  // Called at a negedge; returns at the negedge of the result cycle.
  task automatic run(input int op, input int a, input int r, input int imm, input string tag);
    int res, br, mul;
    model(op, a, r, imm, res, br, mul);
    chk({tag, ":ready"}, ready_o, 1);
    valid_i = 1'b1;
    op_i    = op[3:0];
    a_i     = a[W-1:0];
    r_i     = r[W-1:0];
    imm_i   = imm[W:0];
    @(negedge clk);
    valid_i = 1'b0;
    if (mul != 0) begin
      for (int k = 1; k < W; k++) begin
        chk({tag, ":mul_ready"}, ready_o, 0);
        chk({tag, ":mul_valid"}, valid_o, 0);
        if (k == 2) begin
          valid_i = 1'b1;
          op_i    = 4'b0100;
          a_i     = '1;
          r_i     = '1;
          imm_i   = {1'b0, 8'hC3};
        end
        if (k == 3) valid_i = 1'b0;
        @(negedge clk);
      end
      chk({tag, ":mul_ready_back"}, ready_o, 1);
    end
    chk({tag, ":valid"}, valid_o, 1);
    chk({tag, ":out"}, out_o, res);
    chk({tag, ":branch"}, branch_o, br);
    chk({tag, ":ovf"}, ovf_o, mf);
    $display("[TB] %s op=%h a=%h r=%h imm=%h -> out=%h br=%0d ovf=%0d (exp %h/%0d/%0d)",
             tag, op[3:0], a[W-1:0], r[W-1:0], imm[W:0], out_o, branch_o, ovf_o, res, br, mf);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ":idle_valid"}, valid_o, 0);
    chk({tag, ":idle_branch"}, branch_o, 0);
    chk({tag, ":idle_ovf"}, ovf_o, mf);
  endtask

  initial begin
    int op, a, r, imm;
    repeat (2) @(negedge clk);
    chk("rst:out", out_o, 0);
    chk("rst:valid", valid_o, 0);
    chk("rst:branch", branch_o, 0);
    chk("rst:ovf", ovf_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:ready", ready_o, 1);

    run(4'b0100, 8'hF0, 8'h20, 9'h100, "add_carry");
    run(4'b0100, 8'h01, 8'h01, 9'h100, "add_fwd");
    run(4'b0100, 8'hFF, 8'h01, 9'h05A, "add_ovr");
    run(4'b0111, 8'h01, 8'h33, 9'h011, "bt_ovr");
    idle_chk("gap1");
    run(4'b1000, 8'h00, 8'h40, 9'h100, "bf_taken");
    run(4'b1000, 8'h02, 8'h40, 9'h100, "bf_not");
    run(4'b1010, 8'h03, 8'h05, 9'h100, "lt");
    run(4'b1001, 8'h7E, 8'h7E, 9'h100, "eq");
    run(4'b1101, 8'h81, 8'h01, 9'h100, "lsl1");
    run(4'b1110, 8'h81, 8'h07, 9'h100, "lsr7");
    run(4'b1101, 8'h81, 8'h08, 9'h100, "lsl8");
    run(4'b1110, 8'h81, 200,   9'h100, "lsr200");
    run(4'b1111, 8'h0F, 8'h11, 9'h100, "mul_ff");
    run(4'b1111, 8'h10, 8'h10, 9'h100, "mul_ovf");
    run(4'b1111, 8'h12, 8'h34, 9'h077, "mul_ovr");
    idle_chk("gap2");

    // Abort a multiply with an asynchronous reset three cycles after accept.
    chk("abort:ready", ready_o, 1);
    valid_i = 1'b1; op_i = 4'b1111; a_i = 8'h0F; r_i = 8'h11; imm_i = 9'h100;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    mf = 0;
    chk("abort:out", out_o, 0);
    chk("abort:valid", valid_o, 0);
    chk("abort:branch", branch_o, 0);
    chk("abort:ovf", ovf_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("abort:no_strobe", valid_o, 0);
      chk("abort:ready_after", ready_o, 1);
    end
    run(4'b0001, 8'hA5, 8'h00, 9'h100, "set_after_abort");

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: a = 0;
        1: a = 1;
        default: a = $urandom_range(0, M - 1);
      endcase
      r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W + 2) : $urandom_range(0, M - 1);
      imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, M - 1) : M + $urandom_range(0, M - 1);
      run(op, a, r, imm, "rand");
      if ($urandom_range(0, 4) == 0) idle_chk("rand_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
